// File: rtl/regfile_scoreboard_pkg.sv
// Shared register-file definitions: architectural constants, write-back request
// type and a popcount helper used by the busy-bit scoreboard.
package riscv_rf_pkg;

   localparam int REG_ZERO = 0;
   localparam int XLEN_DEF = 32;
   localparam int NREG_DEF = 32;
   localparam int AW_DEF   = $clog2(NREG_DEF);
   localparam int POP_MAX  = 256;

   typedef struct packed {
      logic                we;
      logic [AW_DEF-1:0]   wa;
      logic [XLEN_DEF-1:0] wd;
   } wb_req_t;

   function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < POP_MAX; i++) n += 32'(v[i]);
      return n;
   endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Bundle between decode/issue plus write-back (master) and the register file (slave).
interface regfile_scoreboard_if
   import riscv_rf_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int NREG   = NREG_DEF,
   parameter int NUM_RD = 2
) ();
   localparam int AW = $clog2(NREG);

   logic [NUM_RD*AW-1:0]   rd_addr;
   logic [NUM_RD*XLEN-1:0] rd_data;
   logic [NUM_RD-1:0]      rd_busy;
   logic                   we0;
   logic [AW-1:0]          wa0;
   logic [XLEN-1:0]        wd0;
   logic                   we1;
   logic [AW-1:0]          wa1;
   logic [XLEN-1:0]        wd1;
   logic                   iss_valid;
   logic [AW-1:0]          iss_rs1;
   logic [AW-1:0]          iss_rs2;
   logic [AW-1:0]          iss_rd;
   logic                   iss_wr;
   logic                   iss_stall;
   logic [AW:0]            pend_cnt;

   modport master (
      output rd_addr, we0, wa0, wd0, we1, wa1, wd1,
             iss_valid, iss_rs1, iss_rs2, iss_rd, iss_wr,
      input  rd_data, rd_busy, iss_stall, pend_cnt
   );

   modport slave (
      input  rd_addr, we0, wa0, wd0, we1, wa1, wd1,
             iss_valid, iss_rs1, iss_rs2, iss_rd, iss_wr,
      output rd_data, rd_busy, iss_stall, pend_cnt
   );

endinterface

// File: rtl/regfile_scoreboard_rf_scoreboard.sv
// Busy-bit scoreboard: tracks in-flight destinations, reports per-port busy,
// raises the issue stall on RAW/WAW hazards and keeps a pending-register count.
module rf_scoreboard
   import riscv_rf_pkg::*;
#(
   parameter  int NREG   = NREG_DEF,
   parameter  int NUM_RD = 2,
   localparam int AW     = $clog2(NREG)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_RD*AW-1:0] i_rd_addr,
   input  logic                 i_we0,
   input  logic [AW-1:0]        i_wa0,
   input  logic                 i_we1,
   input  logic [AW-1:0]        i_wa1,
   input  logic                 i_iss_valid,
   input  logic [AW-1:0]        i_iss_rs1,
   input  logic [AW-1:0]        i_iss_rs2,
   input  logic [AW-1:0]        i_iss_rd,
   input  logic                 i_iss_wr,
   output logic [NUM_RD-1:0]    o_rd_busy,
   output logic                 o_iss_stall,
   output logic [AW:0]          o_pend_cnt
);
   localparam int NPAD = 1 << AW;

   logic [NREG-1:0] r_busy;
   logic [AW:0]     r_pend_cnt;
   logic [NREG-1:0] w_clr, w_set, w_busy_eff, w_busy_next;
   logic [NPAD-1:0] w_eff_pad, w_busy_pad;
   logic            w_dual_busy;

   // NOTE: every always_comb output gets a default before any conditional update, so no latch is inferred.
   always_comb begin
      w_clr = '0;
      for (int i = 1; i < NREG; i++)
         w_clr[i] = (i_we0 && (i_wa0 == AW'(i))) || (i_we1 && (i_wa1 == AW'(i)));
   end

   always_comb begin
      w_set = '0;
      for (int i = 1; i < NREG; i++)
         w_set[i] = i_iss_valid && !o_iss_stall && i_iss_wr && (i_iss_rd == AW'(i));
   end

   // A value on write-back this cycle is forwarded, so it no longer counts as busy.
   assign w_busy_eff  = r_busy & ~w_clr;
   assign w_busy_next = w_busy_eff | w_set;
   assign w_eff_pad   = NPAD'(w_busy_eff);
   assign w_busy_pad  = NPAD'(r_busy);

   assign o_iss_stall = !rst && i_iss_valid &&
                        (w_eff_pad[i_iss_rs1] || w_eff_pad[i_iss_rs2] ||
                         (i_iss_wr && w_eff_pad[i_iss_rd]));

   always_comb begin
      o_rd_busy = '0;
      for (int k = 0; k < NUM_RD; k++)
         o_rd_busy[k] = !rst && w_eff_pad[i_rd_addr[k*AW +: AW]];
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy     <= '0;
         r_pend_cnt <= '0;
      end else begin
         r_busy     <= w_busy_next;
         r_pend_cnt <= (AW+1)'(popcount(POP_MAX'(w_busy_next)));
      end
   end

   assign o_pend_cnt = r_pend_cnt;

   assign w_dual_busy = i_we0 && i_we1 && (i_wa0 == i_wa1) &&
                        (i_wa0 != AW'(REG_ZERO)) && w_busy_pad[i_wa0];

   // Only one producer per register may be in flight.
   a_one_producer: assert property (@(posedge clk) disable iff (rst) !w_dual_busy);

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with N combinational read ports, two write-back ports,
// same-cycle forwarding and a busy-bit scoreboard for issue hazards.
module regfile_scoreboard
   import riscv_rf_pkg::*;
#(
   parameter  int XLEN   = XLEN_DEF,
   parameter  int NREG   = NREG_DEF,
   parameter  int NUM_RD = 2,
   localparam int AW     = $clog2(NREG)
) (
   input  logic                 clk,
   input  logic                 rst,
   regfile_scoreboard_if.slave  bus
);
   localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

   logic [XLEN-1:0] r_mem [NREG];
   logic [AW-1:0]   w_ra  [NUM_RD];
   logic            w_wv0, w_wv1;

   assign w_wv0 = bus.we0 && (bus.wa0 != AW'(REG_ZERO)) && ({1'b0, bus.wa0} < NREG_W);
   assign w_wv1 = bus.we1 && (bus.wa1 != AW'(REG_ZERO)) && ({1'b0, bus.wa1} < NREG_W);

   // NOTE: this is a flop array, not a RAM macro, so clearing every entry on reset is intended.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
      end else begin
         if (w_wv0) r_mem[bus.wa0] <= bus.wd0;
         if (w_wv1) r_mem[bus.wa1] <= bus.wd1;
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_ra
      assign w_ra[k] = bus.rd_addr[k*AW +: AW];
   end

   // Forwarding order lets port 1 override port 0, matching the storage priority.
   always_comb begin
      bus.rd_data = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         if (!rst && (w_ra[k] != AW'(REG_ZERO)) && ({1'b0, w_ra[k]} < NREG_W)) begin
            bus.rd_data[k*XLEN +: XLEN] = r_mem[w_ra[k]];
            if (bus.we0 && (bus.wa0 == w_ra[k])) bus.rd_data[k*XLEN +: XLEN] = bus.wd0;
            if (bus.we1 && (bus.wa1 == w_ra[k])) bus.rd_data[k*XLEN +: XLEN] = bus.wd1;
         end
      end
   end

   rf_scoreboard #(
      .NREG   (NREG),
      .NUM_RD (NUM_RD)
   ) u_sb (
      .clk         (clk),
      .rst         (rst),
      .i_rd_addr   (bus.rd_addr),
      .i_we0       (bus.we0),
      .i_wa0       (bus.wa0),
      .i_we1       (bus.we1),
      .i_wa1       (bus.wa1),
      .i_iss_valid (bus.iss_valid),
      .i_iss_rs1   (bus.iss_rs1),
      .i_iss_rs2   (bus.iss_rs2),
      .i_iss_rd    (bus.iss_rd),
      .i_iss_wr    (bus.iss_wr),
      .o_rd_busy   (bus.rd_busy),
      .o_iss_stall (bus.iss_stall),
      .o_pend_cnt  (bus.pend_cnt)
   );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: default 32x32/2-port instance plus a
// 64-bit, 16-register, 3-port instance.
module tb_regfile_scoreboard;

   logic clk = 1'b0;
   logic rst;
   int   n_pass  = 0;
   int   n_fail  = 0;
   int   n_total = 0;

   always #5 clk = ~clk;

   regfile_scoreboard_if #(.XLEN(32), .NREG(32), .NUM_RD(2)) bus  ();
   regfile_scoreboard_if #(.XLEN(64), .NREG(16), .NUM_RD(3)) pbus ();

   regfile_scoreboard #(.XLEN(32), .NREG(32), .NUM_RD(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   regfile_scoreboard #(.XLEN(64), .NREG(16), .NUM_RD(3)) dut_p (
      .clk (clk),
      .rst (rst),
      .bus (pbus)
   );

   task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle();
      bus.we0 = 1'b0; bus.wa0 = '0; bus.wd0 = '0;
      bus.we1 = 1'b0; bus.wa1 = '0; bus.wd1 = '0;
      bus.iss_valid = 1'b0; bus.iss_wr = 1'b0;
      bus.iss_rs1 = '0; bus.iss_rs2 = '0; bus.iss_rd = '0;
   endtask

   task automatic p_idle();
      pbus.we0 = 1'b0; pbus.wa0 = '0; pbus.wd0 = '0;
      pbus.we1 = 1'b0; pbus.wa1 = '0; pbus.wd1 = '0;
      pbus.iss_valid = 1'b0; pbus.iss_wr = 1'b0;
      pbus.iss_rs1 = '0; pbus.iss_rs2 = '0; pbus.iss_rd = '0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      p_idle();
      bus.rd_addr  = '0;
      pbus.rd_addr = '0;
      tick();
      tick();

      // Activity while in reset is masked and discarded
      bus.we0 = 1'b1; bus.wa0 = 5'd5; bus.wd0 = 32'h0000_00FF;
      bus.iss_valid = 1'b1; bus.iss_wr = 1'b1; bus.iss_rd = 5'd3;
      bus.rd_addr = {5'd0, 5'd5};
      settle();
      check("rst_stall", bus.iss_stall, 1'b0);
      check("rst_rd_data", bus.rd_data, 64'h0);
      check("rst_rd_busy", bus.rd_busy, 2'b00);
      tick();
      rst = 1'b0;
      idle();
      settle();
      check("post_rst_pend", bus.pend_cnt, 6'd0);
      check("post_rst_x5", bus.rd_data[31:0], 32'h0);
      check("post_rst_busy", bus.rd_busy, 2'b00);

      // Register 0 stays zero
      bus.we0 = 1'b1; bus.wa0 = 5'd0; bus.wd0 = 32'hDEAD_BEEF;
      bus.rd_addr = {5'd0, 5'd0};
      settle();
      check("zero_fwd", bus.rd_data[31:0], 32'h0);
      tick();
      idle();
      settle();
      check("zero_store", bus.rd_data[31:0], 32'h0);

      // Dual write to x7: port 1 wins in forwarding and storage
      bus.we0 = 1'b1; bus.wa0 = 5'd7; bus.wd0 = 32'h11;
      bus.we1 = 1'b1; bus.wa1 = 5'd7; bus.wd1 = 32'h22;
      bus.rd_addr = {5'd0, 5'd7};
      settle();
      check("fwd_p1_wins", bus.rd_data[31:0], 32'h22);
      tick();
      idle();
      settle();
      check("store_p1_wins", bus.rd_data[31:0], 32'h22);

      // Port-0-only forwarding seen on read port 1
      bus.we0 = 1'b1; bus.wa0 = 5'd8; bus.wd0 = 32'h33;
      bus.rd_addr = {5'd8, 5'd7};
      settle();
      check("fwd_p0_rdport1", bus.rd_data[63:32], 32'h33);
      check("rd_x7_rdport0", bus.rd_data[31:0], 32'h22);
      tick();
      idle();

      // RAW hazard on x3
      bus.iss_valid = 1'b1; bus.iss_wr = 1'b1; bus.iss_rd = 5'd3;
      settle();
      check("raw_issue_ok", bus.iss_stall, 1'b0);
      tick();
      idle();
      bus.rd_addr = {5'd0, 5'd3};
      settle();
      check("raw_pend1", bus.pend_cnt, 6'd1);
      check("raw_busy3", bus.rd_busy, 2'b01);
      bus.iss_valid = 1'b1; bus.iss_rs1 = 5'd3;
      settle();
      check("raw_stall", bus.iss_stall, 1'b1);
      tick();
      check("raw_stall_hold", bus.iss_stall, 1'b1);
      bus.we1 = 1'b1; bus.wa1 = 5'd3; bus.wd1 = 32'h55;
      settle();
      check("raw_release", bus.iss_stall, 1'b0);
      check("raw_fwd", bus.rd_data[31:0], 32'h55);
      check("raw_busy_eff", bus.rd_busy, 2'b00);
      tick();
      idle();
      settle();
      check("raw_pend0", bus.pend_cnt, 6'd0);
      check("raw_store", bus.rd_data[31:0], 32'h55);

      // Set and clear of x9 in the same cycle: set wins
      bus.iss_valid = 1'b1; bus.iss_wr = 1'b1; bus.iss_rd = 5'd9;
      tick();
      idle();
      bus.rd_addr = {5'd0, 5'd9};
      settle();
      check("coll_pend_before", bus.pend_cnt, 6'd1);
      bus.we0 = 1'b1; bus.wa0 = 5'd9; bus.wd0 = 32'h99;
      bus.iss_valid = 1'b1; bus.iss_wr = 1'b1; bus.iss_rd = 5'd9;
      settle();
      check("coll_no_stall", bus.iss_stall, 1'b0);
      tick();
      idle();
      settle();
      check("coll_busy", bus.rd_busy, 2'b01);
      check("coll_pend", bus.pend_cnt, 6'd1);
      check("coll_data", bus.rd_data[31:0], 32'h99);
      bus.we0 = 1'b1; bus.wa0 = 5'd9; bus.wd0 = 32'h99;
      tick();
      idle();
      settle();
      check("coll_release", bus.pend_cnt, 6'd0);

      // WAW hazard on x4
      bus.iss_valid = 1'b1; bus.iss_wr = 1'b1; bus.iss_rd = 5'd4;
      tick();
      idle();
      settle();
      check("waw_pend1", bus.pend_cnt, 6'd1);
      bus.iss_valid = 1'b1; bus.iss_wr = 1'b1; bus.iss_rd = 5'd4;
      settle();
      check("waw_stall", bus.iss_stall, 1'b1);
      tick();
      check("waw_pend_hold", bus.pend_cnt, 6'd1);
      bus.iss_wr = 1'b0;
      settle();
      check("waw_no_wr", bus.iss_stall, 1'b0);
      bus.iss_rs2 = 5'd4;
      settle();
      check("rs2_stall", bus.iss_stall, 1'b1);
      bus.iss_valid = 1'b0;
      settle();
      check("no_valid_no_stall", bus.iss_stall, 1'b0);
      idle();

      // Write-back to an untracked register leaves busy state alone
      bus.we1 = 1'b1; bus.wa1 = 5'd12; bus.wd1 = 32'hABC;
      tick();
      idle();
      bus.rd_addr = {5'd12, 5'd4};
      settle();
      check("untracked_pend", bus.pend_cnt, 6'd1);
      check("untracked_data", bus.rd_data[63:32], 32'hABC);
      check("rd_busy_mix", bus.rd_busy, 2'b01);

      // Mid-run reset
      bus.we0 = 1'b1; bus.wa0 = 5'd5; bus.wd0 = 32'h1234;
      tick();
      idle();
      bus.rd_addr = {5'd4, 5'd5};
      settle();
      check("x5_before_rst", bus.rd_data[31:0], 32'h1234);
      check("x4_busy_before_rst", bus.rd_busy, 2'b10);
      rst = 1'b1;
      settle();
      check("rst_masks_rd", bus.rd_data, 64'h0);
      check("rst_masks_busy", bus.rd_busy, 2'b00);
      tick();
      rst = 1'b0;
      settle();
      check("mid_rst_x5", bus.rd_data[31:0], 32'h0);
      check("mid_rst_pend", bus.pend_cnt, 6'd0);
      check("mid_rst_busy", bus.rd_busy, 2'b00);

      // 64-bit, 16-register, 3-port instance
      pbus.we0 = 1'b1; pbus.wa0 = 4'd1;  pbus.wd0 = 64'h0123_4567_89AB_CDEF;
      pbus.we1 = 1'b1; pbus.wa1 = 4'd15; pbus.wd1 = 64'hFEDC_BA98_7654_3210;
      tick();
      pbus.we0 = 1'b1; pbus.wa0 = 4'd10; pbus.wd0 = 64'hA5A5_0000_FFFF_5A5A;
      pbus.we1 = 1'b0;
      tick();
      p_idle();
      pbus.rd_addr = {4'd10, 4'd15, 4'd1};
      settle();
      check("p_port0_x1", pbus.rd_data[63:0], 64'h0123_4567_89AB_CDEF);
      check("p_port1_x15", pbus.rd_data[127:64], 64'hFEDC_BA98_7654_3210);
      check("p_port2_x10", pbus.rd_data[191:128], 64'hA5A5_0000_FFFF_5A5A);
      check("p_pend", pbus.pend_cnt, 5'd0);
      pbus.rd_addr = '0;
      settle();
      check("p_all_zero", pbus.rd_data, 192'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
